// File: rtl/ocd_inject_buffer_if.sv
// Debugger/core-side signal bundle for the per-core injection buffer.
// master = debugger controller + pipeline side, slave = the buffer itself.
interface ocd_inject_buffer_if #(
    parameter int unsigned CORE_ID_WIDTH    = 4,
    parameter int unsigned THREAD_IDX_WIDTH = 2
);
    logic                        ocd_halt;
    logic [THREAD_IDX_WIDTH-1:0] ocd_thread;
    logic [CORE_ID_WIDTH-1:0]    ocd_core;
    logic [31:0]                 ocd_inject_inst;
    logic                        ocd_inject_en;
    logic [31:0]                 ocd_data_from_host;
    logic                        ocd_data_update;
    logic                        inject_valid;
    logic [31:0]                 inject_inst;
    logic [THREAD_IDX_WIDTH-1:0] inject_thread;
    logic                        inject_ready;
    logic                        wb_inject_complete;
    logic                        wb_inject_rollback;
    logic                        cr_jtag_data_we;
    logic [31:0]                 cr_jtag_data_wdata;
    logic [31:0]                 jtag_data;
    logic                        injected_complete;
    logic                        injected_rollback;
    logic                        inject_overflow;

    modport master (
        output ocd_halt, ocd_thread, ocd_core, ocd_inject_inst, ocd_inject_en,
        output ocd_data_from_host, ocd_data_update, inject_ready,
        output wb_inject_complete, wb_inject_rollback, cr_jtag_data_we, cr_jtag_data_wdata,
        input  inject_valid, inject_inst, inject_thread, jtag_data,
        input  injected_complete, injected_rollback, inject_overflow
    );

    modport slave (
        input  ocd_halt, ocd_thread, ocd_core, ocd_inject_inst, ocd_inject_en,
        input  ocd_data_from_host, ocd_data_update, inject_ready,
        input  wb_inject_complete, wb_inject_rollback, cr_jtag_data_we, cr_jtag_data_wdata,
        output inject_valid, inject_inst, inject_thread, jtag_data,
        output injected_complete, injected_rollback, inject_overflow
    );
endinterface

// File: rtl/ocd_inject_buffer.sv
// Queues debugger-injected instructions for one core, keeps one in flight,
// reports complete/rollback, and holds the bidirectional JTAG_DATA register.
module ocd_inject_buffer #(
    parameter int unsigned CORE_ID          = 0,
    parameter int unsigned QUEUE_DEPTH      = 4,
    parameter int unsigned CORE_ID_WIDTH    = 4,
    parameter int unsigned THREAD_IDX_WIDTH = 2
) (
    input logic                clk,
    input logic                reset,
    ocd_inject_buffer_if.slave ocd_if
);
    localparam int unsigned PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned ENTRY_W = THREAD_IDX_WIDTH + 32;

    typedef enum logic {IDLE, ISSUED} state_e;

    state_e             state_q, state_d;
    logic [ENTRY_W-1:0] mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               halt_q;
    logic               overflow_q, overflow_d;
    logic               complete_q, complete_d;
    logic               rollback_q, rollback_d;
    logic [31:0]        jtag_q, jtag_d;

    logic               enq_req, enq_ok, empty, full, issue, pop, flush;
    logic [ENTRY_W-1:0] head;

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(QUEUE_DEPTH));

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        complete_d = 1'b0;
        rollback_d = 1'b0;
        jtag_d     = jtag_q;

        enq_req = ocd_if.ocd_inject_en && ocd_if.ocd_halt &&
                  (ocd_if.ocd_core == CORE_ID_WIDTH'(CORE_ID));
        issue   = (state_q == IDLE) && !empty && ocd_if.ocd_halt;
        pop     = issue && ocd_if.inject_ready;

        case (state_q)
            IDLE: if (pop) state_d = ISSUED;
            ISSUED: begin
                rollback_d = ocd_if.wb_inject_rollback;
                complete_d = ocd_if.wb_inject_complete && !ocd_if.wb_inject_rollback;
                if (ocd_if.wb_inject_complete || ocd_if.wb_inject_rollback) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush (rollback or halt falling edge) never coincides with a pop,
        // and a same-cycle enqueue lands in the freshly emptied queue.
        flush  = rollback_d || (halt_q && !ocd_if.ocd_halt);
        enq_ok = enq_req && (!full || pop || flush);

        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q - CNT_W'(1);
        end
        if (enq_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_d + CNT_W'(1);
        end

        overflow_d = overflow_q || (enq_req && !enq_ok);

        if (ocd_if.ocd_data_update)      jtag_d = ocd_if.ocd_data_from_host;
        else if (ocd_if.cr_jtag_data_we) jtag_d = ocd_if.cr_jtag_data_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            halt_q     <= 1'b0;
            overflow_q <= 1'b0;
            complete_q <= 1'b0;
            rollback_q <= 1'b0;
            jtag_q     <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            halt_q     <= ocd_if.ocd_halt;
            overflow_q <= overflow_d;
            complete_q <= complete_d;
            rollback_q <= rollback_d;
            jtag_q     <= jtag_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (!reset && enq_ok) mem_q[wr_ptr_q] <= {ocd_if.ocd_thread, ocd_if.ocd_inject_inst};
    end

    assign ocd_if.inject_valid      = issue;
    assign ocd_if.inject_inst       = issue ? head[31:0] : '0;
    assign ocd_if.inject_thread     = issue ? head[ENTRY_W-1:32] : '0;
    assign ocd_if.jtag_data         = jtag_q;
    assign ocd_if.injected_complete = complete_q;
    assign ocd_if.injected_rollback = rollback_q;
    assign ocd_if.inject_overflow   = overflow_q;

    a_wb_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(ocd_if.wb_inject_complete && ocd_if.wb_inject_rollback));
endmodule

// File: doc/ocd_inject_buffer.md
Name: ocd_inject_buffer

Overview:
- Per-core injection stage between the on-chip debugger controller and the core's thread-select stage.
- Buffers machine instructions injected by the debugger until the pipeline can accept them, so no instruction is lost when the pipeline is busy.
- Enforces one injected instruction in flight and reports completion or rollback back to the debugger.
- Owns the JTAG_DATA register that carries data between the host and the core in both directions.

Parameters:
- CORE_ID, 0, core_id_t value this instance responds to.
- QUEUE_DEPTH, 4, number of injected-instruction entries; must be a power of two, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ocd_halt  in  1  debugger halt request
- ocd_thread  in  local_thread_idx_t  target thread for injection
- ocd_core  in  core_id_t  target core
- ocd_inject_inst  in  32  instruction word from the debugger
- ocd_inject_en  in  1  single-cycle inject strobe
- ocd_data_from_host  in  32  host data to write into JTAG_DATA
- ocd_data_update  in  1  JTAG_DATA host-write strobe
- inject_valid  out  1  instruction offered to thread select
- inject_inst  out  32  offered instruction
- inject_thread  out  local_thread_idx_t  thread of the offered instruction
- inject_ready  in  1  thread select accepts this cycle
- wb_inject_complete  in  1  injected instruction retired
- wb_inject_rollback  in  1  injected instruction rolled back
- cr_jtag_data_we  in  1  core write to the JTAG_DATA control register
- cr_jtag_data_wdata  in  32  core write data
- jtag_data  out  32  JTAG_DATA register value, also driven as data_to_host
- injected_complete  out  1  one-cycle pulse to the debugger
- injected_rollback  out  1  one-cycle pulse to the debugger
- inject_overflow  out  1  sticky flag: an inject was dropped because the queue was full

Behaviour:
- Reset (synchronous): queue empty, state IDLE, all outputs 0, jtag_data 0, inject_overflow 0. Reset mid-operation discards queued and in-flight instructions; no completion pulse is generated for them.
- Enqueue condition: ocd_inject_en && ocd_core == CORE_ID && ocd_halt. Each entry stores {ocd_thread, ocd_inject_inst}.
- Injects that arrive while ocd_halt is low, or that target another core, are ignored and do not set the overflow flag.
- Queue is a circular FIFO. The occupancy counter is $clog2(QUEUE_DEPTH+1) bits; read and write pointers wrap modulo QUEUE_DEPTH.
- Full:
  - An enqueue while full with no same-cycle pop is dropped and sets inject_overflow, which stays set until reset.
  - An enqueue while full with a same-cycle pop is accepted.
- State machine:
  - IDLE: inject_valid = !empty && ocd_halt. inject_inst and inject_thread come combinationally from the head entry.
  - IDLE -> ISSUED when inject_valid && inject_ready; the head entry is popped in that same cycle.
  - ISSUED: inject_valid = 0.
  - ISSUED -> IDLE on wb_inject_complete; injected_complete pulses in the next cycle.
  - ISSUED -> IDLE on wb_inject_rollback; injected_rollback pulses in the next cycle and the queue is flushed, because later instructions depend on the rolled-back one.
  - The debugger reissues after a rollback.
- wb_inject_complete and wb_inject_rollback seen in IDLE are ignored.
- Simultaneous wb_inject_complete and wb_inject_rollback is illegal and is asserted against; if it occurs, rollback wins.
- Rollback flush and enqueue in the same cycle: the flush applies first, then the new entry is written, giving occupancy 1.
- Falling edge of ocd_halt:
  - The queue is flushed in the following cycle.
  - An in-flight instruction still waits in ISSUED for its complete or rollback.
- Minimum latency: with the queue empty and inject_ready high, inject_valid asserts the cycle after ocd_inject_en. Throughput is at most one injected instruction per complete/rollback round trip.
- JTAG_DATA register:
  - ocd_data_update loads ocd_data_from_host.
  - cr_jtag_data_we loads cr_jtag_data_wdata.
  - If both occur in the same cycle, the host write wins.
  - Write to read-back latency is 1 cycle.

Test Plan:
- Halted, inject 0x12345678 for thread 2 with inject_ready=1 -> next cycle inject_valid=1, inject_inst=0x12345678, inject_thread=2. After accept, wb_inject_complete -> injected_complete pulses for exactly 1 cycle.
- inject_ready=0, inject 5 instructions with QUEUE_DEPTH=4 -> the first 4 are held and inject_overflow=1. Then raise inject_ready and retire each one -> issued strictly in order, one at a time, and the 5th never appears.
- Queue 3 entries, accept the first, then assert wb_inject_rollback -> injected_rollback pulses, the queue is empty, and inject_valid stays 0.
- In the same cycle, ocd_data_update with 0xAAAA0000 and cr_jtag_data_we with 0x5555FFFF -> jtag_data=0xAAAA0000. A later core-only write of 0x5555FFFF -> jtag_data=0x5555FFFF.
- ocd_core != CORE_ID, or ocd_halt=0, during an inject -> no enqueue and inject_overflow stays 0.
- Drop ocd_halt with 2 entries queued and 1 in flight -> the queue is flushed, the in-flight instruction still completes with an injected_complete pulse, then reset returns every output to 0.
